sram_access_seq: RTL and testbench

- Request sequencer sitting directly upstream of the 2R1W wordline decoder in the SRAM macro.
- Accepts one bundled access request (up to two reads plus one write) through a valid/ready handshake and registers the addresses.
- Drives the decoder's address_1, address_2, read_enable[1:0] and write_enable through a precharge -> wordline -> sense timing sequence.
- Reads are always serviced before the write of the same request, so a read-then-write to one row returns the old data.

---
 rtl/sram_access_seq.sv | 153 +++++++++++++++
 tb/tb_sram_access_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_seq.sv
// Request sequencer for the 2R1W wordline decoder: precharge -> wordline -> sense, reads before write.
// Optional address range check enabled by defining SRAM_SEQ_ADDR_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// R_PRE   | bitline precharge ahead of the read wordline
// R_WL    | read wordlines asserted
// R_SENSE | one-cycle sense-amp strobe
// W_PRE   | bitline precharge ahead of the write wordline, address_1 holds waddr
// W_WL    | write wordline asserted
// FIN     | one-cycle done pulse
module sram_access_seq #(
    parameter int ADDR_W     = 7,
    parameter int DEPTH      = 128,
    parameter int PRE_CYCLES = 2,
    parameter int WL_CYCLES  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rd1,
    input  logic              req_rd2,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [ADDR_W-1:0] req_waddr,
    output logic [ADDR_W-1:0] address_1,
    output logic [ADDR_W-1:0] address_2,
    output logic [1:0]        read_enable,
    output logic              write_enable,
    output logic              precharge,
    output logic              sense_en,
    output logic              done,
    output logic              err
);

`ifdef SRAM_SEQ_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    localparam int MAX_CYC = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, R_PRE, R_WL, R_SENSE, W_PRE, W_WL, FIN
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              rd1_q, rd2_q, wr_q;
    logic [ADDR_W-1:0] waddr_q;

    logic accept;
    logic rd1_ok, rd2_ok, wr_ok;
    logic rd1_in, rd2_in, wr_in, drop;

    // Out-of-range operations are dropped at accept; the check folds away when disabled.
    always_comb begin
        accept = req_valid && req_ready;
        rd1_ok = !ADDR_CHECK || (32'(req_addr1) < 32'(DEPTH));
        rd2_ok = !ADDR_CHECK || (32'(req_addr2) < 32'(DEPTH));
        wr_ok  = !ADDR_CHECK || (32'(req_waddr) < 32'(DEPTH));
        rd1_in = req_rd1 && rd1_ok;
        rd2_in = req_rd2 && rd2_ok;
        wr_in  = req_wr && wr_ok;
        drop   = (req_rd1 && !rd1_ok) || (req_rd2 && !rd2_ok) || (req_wr && !wr_ok);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (rd1_in || rd2_in) state_next = R_PRE;
                    else if (wr_in)       state_next = W_PRE;
                    else                  state_next = FIN;
                end
            end
            R_PRE:   if (cnt == '0) state_next = R_WL;
            R_WL:    if (cnt == '0) state_next = R_SENSE;
            R_SENSE: state_next = wr_q ? W_PRE : FIN;
            W_PRE:   if (cnt == '0) state_next = W_WL;
            W_WL:    if (cnt == '0) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                case (state_next)
                    R_PRE, W_PRE: cnt <= PRE_LOAD;
                    R_WL, W_WL:   cnt <= WL_LOAD;
                    default:      cnt <= '0;
                endcase
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_q     <= 1'b0;
            rd2_q     <= 1'b0;
            wr_q      <= 1'b0;
            waddr_q   <= '0;
            address_1 <= '0;
            address_2 <= '0;
        end else if (accept) begin
            rd1_q     <= rd1_in;
            rd2_q     <= rd2_in;
            wr_q      <= wr_in;
            waddr_q   <= req_waddr;
            address_1 <= (rd1_in || rd2_in) ? req_addr1 : req_waddr;
            address_2 <= req_addr2;
        end else if (state == R_SENSE && state_next == W_PRE) begin
            address_1 <= waddr_q;
        end
    end

    // Decoder controls are registered from the next state so they change only on the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready    <= 1'b1;
            precharge    <= 1'b0;
            read_enable  <= 2'b00;
            write_enable <= 1'b0;
            sense_en     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            req_ready    <= (state_next == IDLE);
            precharge    <= (state_next == R_PRE) || (state_next == W_PRE);
            read_enable  <= (state_next == R_WL) ? {rd1_q, rd2_q} : 2'b00;
            write_enable <= (state_next == W_WL);
            sense_en     <= (state_next == R_SENSE);
            done         <= (state_next == FIN);
            err          <= accept && drop;
        end
    end

endmodule

// File: tb/tb_sram_access_seq.sv
// Self-checking bench for sram_access_seq: directed and random requests against a phase-timeline model.
module tb_sram_access_seq;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 100;
    localparam int PRE    = 2;
    localparam int WL     = 3;
`ifdef SRAM_SEQ_ADDR_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_rd1, req_rd2, req_wr;
    logic [ADDR_W-1:0] req_addr1, req_addr2, req_waddr;
    logic [ADDR_W-1:0] address_1, address_2;
    logic [1:0]        read_enable;
    logic              write_enable, precharge, sense_en, done, err;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    sram_access_seq #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PRE_CYCLES(PRE), .WL_CYCLES(WL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd1(req_rd1), .req_rd2(req_rd2), .req_wr(req_wr),
        .req_addr1(req_addr1), .req_addr2(req_addr2), .req_waddr(req_waddr),
        .address_1(address_1), .address_2(address_2),
        .read_enable(read_enable), .write_enable(write_enable),
        .precharge(precharge), .sense_en(sense_en), .done(done), .err(err)
    );

    function automatic logic [7:0] out_vec();
        return {req_ready, precharge, read_enable, write_enable, sense_en, done, err};
    endfunction

    // Cycle of the done pulse, counting the cycle right after accept as 1.
    function automatic int done_cycle(input bit r1, input bit r2, input bit w);
        int t = 1;
        if (r1 || r2) t += PRE + WL + 1;
        if (w) t += PRE + WL;
        return t;
    endfunction

    // Expected {ready, precharge, read_enable, write_enable, sense, done, err} at cycle k after accept.
    function automatic logic [7:0] exp_vec(input int k, input bit r1, input bit r2, input bit w,
                                           input bit e, input int d);
        int t = 1;
        logic pc = 1'b0;
        logic [1:0] re = 2'b00;
        logic we = 1'b0;
        logic se = 1'b0;
        if (r1 || r2) begin
            if (k >= t && k < t + PRE) pc = 1'b1;
            if (k >= t + PRE && k < t + PRE + WL) re = {r1, r2};
            if (k == t + PRE + WL) se = 1'b1;
            t += PRE + WL + 1;
        end
        if (w) begin
            if (k >= t && k < t + PRE) pc = 1'b1;
            if (k >= t + PRE && k < t + PRE + WL) we = 1'b1;
        end
        return {(k > d), pc, re, we, se, (k == d), (e && k == 1)};
    endfunction

    // Issue one request from an idle negedge and check every cycle through the return to idle.
    task automatic run_req(input bit r1, input bit r2, input bit w,
                           input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                           input logic [ADDR_W-1:0] wa, input bit hold, input string tag);
        bit e1, e2, ew, er;
        int d;
        logic [7:0] got, exp;
        e1 = r1 && (!CHECK || int'(a1) < DEPTH);
        e2 = r2 && (!CHECK || int'(a2) < DEPTH);
        ew = w && (!CHECK || int'(wa) < DEPTH);
        er = (r1 && !e1) || (r2 && !e2) || (w && !ew);
        d  = done_cycle(e1, e2, ew);
        checks++;
        if (req_ready !== 1'b1)
            $display("FAIL %s ready_at_issue got=%b want=1", tag, req_ready);
        else passes++;
        req_rd1 = r1; req_rd2 = r2; req_wr = w;
        req_addr1 = a1; req_addr2 = a2; req_waddr = wa;
        req_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= d + 1; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) req_valid = 1'b0;
            got = out_vec();
            exp = exp_vec(k, e1, e2, ew, er, d);
            checks++;
            if (got !== exp)
                $display("FAIL %s cycle%0d outputs got=%b want=%b", tag, k, got, exp);
            else passes++;
            if (exp[5] || exp[3]) begin
                checks++;
                if (address_1 !== (exp[3] ? wa : a1))
                    $display("FAIL %s cycle%0d address_1 got=%h want=%h", tag, k, address_1,
                             exp[3] ? wa : a1);
                else passes++;
            end
            if (exp[4]) begin
                checks++;
                if (address_2 !== a2)
                    $display("FAIL %s cycle%0d address_2 got=%h want=%h", tag, k, address_2, a2);
                else passes++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_rd1 = 1'b0; req_rd2 = 1'b0; req_wr = 1'b0;
        req_addr1 = '0; req_addr2 = '0; req_waddr = '0;
        #1;
        checks++;
        if ({out_vec(), address_1, address_2} !== {8'b1000_0000, 7'h00, 7'h00})
            $display("FAIL reset outputs got=%b a1=%h a2=%h want=10000000 0 0",
                     out_vec(), address_1, address_2);
        else passes++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dual_read();
        run_req(1, 1, 0, 7'h3C, 7'h4F, 7'h00, 0, "dual_read");
    endtask

    task automatic test_write_only();
        run_req(0, 0, 1, 7'h00, 7'h00, 7'h3C, 0, "write_only");
    endtask

    task automatic test_read_write_same_row();
        run_req(1, 0, 1, 7'h4F, 7'h11, 7'h4F, 0, "rd_wr_same_row");
    endtask

    task automatic test_no_flags();
        run_req(0, 0, 0, 7'h12, 7'h34, 7'h56, 0, "no_flags");
    endtask

    task automatic test_back_to_back();
        run_req(1, 1, 0, 7'h05, 7'h05, 7'h00, 1, "b2b_first");
        run_req(0, 1, 1, 7'h00, 7'h22, 7'h33, 1, "b2b_second");
        run_req(1, 0, 0, 7'h7F, 7'h00, 7'h00, 0, "b2b_third");
    endtask

    task automatic test_addr_check();
        run_req(1, 0, 1, 7'h70, 7'h00, 7'h10, 0, "addr_check");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                    7'($urandom_range(0, 127)),
                    (n != 29) && ($urandom_range(0, 1) == 1), "random");
        end
    endtask

    task automatic test_reset_mid_op();
        req_rd1 = 1'b1; req_rd2 = 1'b1; req_wr = 1'b0;
        req_addr1 = 7'h2A; req_addr2 = 7'h15; req_waddr = 7'h00;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (read_enable !== 2'b11)
            $display("FAIL reset_mid_op precondition read_enable got=%b want=11", read_enable);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({read_enable, precharge, req_ready, write_enable, done} !== 6'b00_0100)
            $display("FAIL reset_mid_op async got re=%b pc=%b rdy=%b we=%b dn=%b want 00 0 1 0 0",
                     read_enable, precharge, req_ready, write_enable, done);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_vec() !== 8'b1000_0000)
            $display("FAIL reset_mid_op idle_after got=%b want=10000000", out_vec());
        else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dual_read();
        test_write_only();
        test_read_write_same_row();
        test_no_flags();
        test_back_to_back();
        test_addr_check();
        test_random();
        test_reset_mid_op();
        run_req(0, 1, 0, 7'h00, 7'h09, 7'h00, 0, "after_reset");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
